// File: rtl/hockey_pkg.sv
// Shared types and helpers for the air-hockey controller.
// State codes, direction codes and the wall-reflection step.
package hockey_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE      = 4'd0;
   localparam state_t S_DISPLAY   = 4'd1;
   localparam state_t S_HIT_A     = 4'd2;
   localparam state_t S_HIT_B     = 4'd3;
   localparam state_t S_SEND_A    = 4'd4;
   localparam state_t S_SEND_B    = 4'd5;
   localparam state_t S_RESP_A    = 4'd6;
   localparam state_t S_RESP_B    = 4'd7;
   localparam state_t S_GOAL_A    = 4'd8;
   localparam state_t S_GOAL_B    = 4'd9;
   localparam state_t S_GAME_OVER = 4'd10;

   localparam logic [1:0] DIR_STRAIGHT = 2'b00;
   localparam logic [1:0] DIR_UP       = 2'b01;
   localparam logic [1:0] DIR_DOWN     = 2'b10;

   typedef struct packed {
      logic [1:0]  dir;
      logic [15:0] y;
   } step_t;

   // One vertical step; bounces off the top/bottom rows.
   function automatic step_t reflect_step(
      input logic [1:0]  dir,
      input logic [15:0] y,
      input logic [15:0] ymax
   );
      step_t s;
      s.dir = dir;
      s.y   = y;
      case (dir)
         DIR_UP: begin
            if (y == ymax) begin
               s.dir = DIR_DOWN;
               s.y   = y - 16'd1;
            end else begin
               s.y = y + 16'd1;
            end
         end
         DIR_DOWN: begin
            if (y == 16'd0) begin
               s.dir = DIR_UP;
               s.y   = y + 16'd1;
            end else begin
               s.y = y - 16'd1;
            end
         end
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/hockey_arena_if.sv
// Player-input / display-output bundle of the air-hockey controller.
// master drives the players and tick, slave is the controller.
interface hockey_arena_if #(
   parameter int COLS      = 5,
   parameter int ROWS      = 5,
   parameter int WIN_SCORE = 3
);
   localparam int XW = $clog2(COLS);
   localparam int YW = $clog2(ROWS);
   localparam int SW = $clog2(WIN_SCORE + 1);

   logic          tick;
   logic          btn_a;
   logic          btn_b;
   logic [1:0]    dir_a;
   logic [1:0]    dir_b;
   logic [YW-1:0] y_in_a;
   logic [YW-1:0] y_in_b;
   logic [XW-1:0] x_coord;
   logic [YW-1:0] y_coord;
   logic [3:0]    state_o;
   logic [SW-1:0] score_a;
   logic [SW-1:0] score_b;
   logic          game_over;
   logic          winner;

   modport master (
      output tick, btn_a, btn_b, dir_a, dir_b,
      output y_in_a, y_in_b,
      input  x_coord, y_coord, state_o,
      input  score_a, score_b, game_over, winner
   );

   modport slave (
      input  tick, btn_a, btn_b, dir_a, dir_b,
      input  y_in_a, y_in_b,
      output x_coord, y_coord, state_o,
      output score_a, score_b, game_over, winner
   );

endinterface

// File: rtl/hockey_tick_timer.sv
// Tick-gated dwell counter with clear and terminal-count strobe.
// done fires on the tick that completes `limit` ticks.
module hockey_tick_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         tick,
   input  logic [W-1:0] limit,
   output logic         done
);

   logic [W-1:0] cnt;

   assign done = tick &&
      (({1'b0, cnt} + (W+1)'(1)) >= {1'b0, limit});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr || done) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hockey_arena.sv
// Air-hockey game controller: serve, flight, returns, goals, game end.
// All dwell and flight timing is counted in tick strobes.
module hockey_arena
   import hockey_pkg::*;
#(
   parameter int COLS           = 5,
   parameter int ROWS           = 5,
   parameter int WIN_SCORE      = 3,
   parameter int STEP_TICKS     = 3,
   parameter int MIN_STEP_TICKS = 1,
   parameter int RESP_TICKS     = 3,
   parameter int HOLD_TICKS     = 3,
   parameter int SPEEDUP        = 1
) (
   input  logic         clk,
   input  logic         rst,
   hockey_arena_if.slave io
);

   localparam int XW = $clog2(COLS);
   localparam int YW = $clog2(ROWS);
   localparam int SW = $clog2(WIN_SCORE + 1);
   localparam int T1 =
      (STEP_TICKS > RESP_TICKS) ? STEP_TICKS : RESP_TICKS;
   localparam int TMAX = (T1 > HOLD_TICKS) ? T1 : HOLD_TICKS;
   localparam int TW = $clog2(TMAX + 1);

   localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
   localparam logic [XW-1:0] X_RB  = XW'(COLS - 2);
   localparam logic [XW-1:0] X_ONE = XW'(1);
   localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
   localparam logic [SW-1:0] S_WIN = SW'(WIN_SCORE);
   localparam logic [TW-1:0] P_STEP = TW'(STEP_TICKS);
   localparam logic [TW-1:0] P_MIN  = TW'(MIN_STEP_TICKS);
   localparam logic [TW-1:0] P_RESP = TW'(RESP_TICKS);
   localparam logic [TW-1:0] P_HOLD = TW'(HOLD_TICKS);

   state_t        st, st_n;
   logic [XW-1:0] x, x_n;
   logic [YW-1:0] y, y_n;
   logic [1:0]    dir, dir_n;
   logic [TW-1:0] per, per_n, per_ret;
   logic [SW-1:0] sa, sa_n, sb, sb_n;
   logic          go, go_n;
   logic          win, win_n;
   logic          srv_b, srv_b_n;
   logic [TW-1:0] lim;
   logic          done;
   step_t         s;

   hockey_tick_timer #(.W(TW)) u_tmr (
      .clk   (clk),
      .rst   (rst),
      .clr   (st_n != st),
      .tick  (io.tick),
      .limit (lim),
      .done  (done)
   );

   always_comb begin
      case (st)
         S_SEND_A, S_SEND_B: lim = per;
         S_RESP_A, S_RESP_B: lim = P_RESP;
         default:            lim = P_HOLD;
      endcase
   end

   // Returned puck speeds up, floored at the minimum period.
   always_comb begin
      per_ret = per;
      if (SPEEDUP != 0) begin
         per_ret = (per > P_MIN) ? per - 1'b1 : P_MIN;
      end
   end

   always_comb begin
      st_n    = st;
      x_n     = x;
      y_n     = y;
      dir_n   = dir;
      per_n   = per;
      sa_n    = sa;
      sb_n    = sb;
      go_n    = go;
      win_n   = win;
      srv_b_n = srv_b;
      s       = '0;
      case (st)
         S_IDLE: begin
            if (io.btn_a || io.btn_b) begin
               srv_b_n = !io.btn_a;
               sa_n    = '0;
               sb_n    = '0;
               go_n    = 1'b0;
               win_n   = 1'b0;
               st_n    = S_DISPLAY;
            end
         end
         S_DISPLAY: begin
            if (done) st_n = srv_b ? S_HIT_B : S_HIT_A;
         end
         S_HIT_A: begin
            if (io.btn_a && io.y_in_a <= Y_MAX) begin
               x_n   = '0;
               y_n   = io.y_in_a;
               dir_n = io.dir_a;
               per_n = P_STEP;
               st_n  = S_SEND_B;
            end
         end
         S_HIT_B: begin
            if (io.btn_b && io.y_in_b <= Y_MAX) begin
               x_n   = X_MAX;
               y_n   = io.y_in_b;
               dir_n = io.dir_b;
               per_n = P_STEP;
               st_n  = S_SEND_A;
            end
         end
         S_SEND_B: begin
            if (done) begin
               s     = reflect_step(dir, 16'(y), 16'(Y_MAX));
               y_n   = s.y[YW-1:0];
               dir_n = s.dir;
               x_n   = x + 1'b1;
               if (x + 1'b1 == X_MAX) st_n = S_RESP_B;
            end
         end
         S_SEND_A: begin
            if (done) begin
               s     = reflect_step(dir, 16'(y), 16'(Y_MAX));
               y_n   = s.y[YW-1:0];
               dir_n = s.dir;
               x_n   = x - 1'b1;
               if (x == X_ONE) st_n = S_RESP_A;
            end
         end
         S_RESP_B: begin
            if (io.btn_b && io.y_in_b == y) begin
               s     = reflect_step(io.dir_b, 16'(y), 16'(Y_MAX));
               y_n   = s.y[YW-1:0];
               dir_n = s.dir;
               x_n   = X_RB;
               per_n = per_ret;
               st_n  = S_SEND_A;
            end else if (done) begin
               sa_n = (sa == S_WIN) ? sa : sa + 1'b1;
               st_n = S_GOAL_A;
            end
         end
         S_RESP_A: begin
            if (io.btn_a && io.y_in_a == y) begin
               s     = reflect_step(io.dir_a, 16'(y), 16'(Y_MAX));
               y_n   = s.y[YW-1:0];
               dir_n = s.dir;
               x_n   = X_ONE;
               per_n = per_ret;
               st_n  = S_SEND_B;
            end else if (done) begin
               sb_n = (sb == S_WIN) ? sb : sb + 1'b1;
               st_n = S_GOAL_B;
            end
         end
         S_GOAL_A: begin
            if (done) begin
               if (sa == S_WIN) begin
                  go_n  = 1'b1;
                  win_n = 1'b0;
                  st_n  = S_GAME_OVER;
               end else begin
                  st_n = S_HIT_B;
               end
            end
         end
         S_GOAL_B: begin
            if (done) begin
               if (sb == S_WIN) begin
                  go_n  = 1'b1;
                  win_n = 1'b1;
                  st_n  = S_GAME_OVER;
               end else begin
                  st_n = S_HIT_A;
               end
            end
         end
         S_GAME_OVER: begin
            if (done) st_n = S_IDLE;
         end
         default: st_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st    <= S_IDLE;
         x     <= '0;
         y     <= '0;
         dir   <= DIR_STRAIGHT;
         per   <= P_STEP;
         sa    <= '0;
         sb    <= '0;
         go    <= 1'b0;
         win   <= 1'b0;
         srv_b <= 1'b0;
      end else begin
         st    <= st_n;
         x     <= x_n;
         y     <= y_n;
         dir   <= dir_n;
         per   <= per_n;
         sa    <= sa_n;
         sb    <= sb_n;
         go    <= go_n;
         win   <= win_n;
         srv_b <= srv_b_n;
      end
   end

   assign io.x_coord   = x;
   assign io.y_coord   = y;
   assign io.state_o   = st;
   assign io.score_a   = sa;
   assign io.score_b   = sb;
   assign io.game_over = go;
   assign io.winner    = win;

endmodule

// File: tb/tb_hockey_arena.sv
// Directed-vector bench for hockey_arena: default 5x5 arena
// plus an 8x3 arena for reflection and row-range checks.
module tb_hockey_arena;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   nchk = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   hockey_arena_if #(.COLS(5), .ROWS(5), .WIN_SCORE(3)) bus0 ();
   hockey_arena_if #(.COLS(8), .ROWS(3), .WIN_SCORE(3)) bus1 ();

   hockey_arena u0 (.clk(clk), .rst(rst), .io(bus0));

   hockey_arena #(.COLS(8), .ROWS(3)) u1 (
      .clk(clk), .rst(rst), .io(bus1)
   );

   task automatic chk(input string tag, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int st_of(input int w);
      return (w != 0) ? int'(bus1.state_o) : int'(bus0.state_o);
   endfunction

   function automatic int x_of(input int w);
      return (w != 0) ? int'(bus1.x_coord) : int'(bus0.x_coord);
   endfunction

   task automatic wait_st(input int w, input int exp,
                          input int budget, input string tag);
      int n = 0;
      while (st_of(w) != exp && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, st_of(w), exp);
   endtask

   task automatic gap(input int w, input int exp, input string tag);
      int x0 = x_of(w);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (x_of(w) == x0 && n < 20);
      chk(tag, n, exp);
   endtask

   task automatic chk_xy(input string tag, input int xe, input int ye);
      chk({tag, "_x"}, int'(bus0.x_coord), xe);
      chk({tag, "_y"}, int'(bus0.y_coord), ye);
   endtask

   int xt[4] = '{1, 2, 3, 4};
   int yt[4] = '{3, 4, 3, 2};
   int y8[7] = '{1, 2, 1, 0, 1, 2, 1};

   initial begin
      bus0.tick = 1'b1; bus1.tick = 1'b1;
      bus0.btn_a = 0; bus0.btn_b = 0; bus0.dir_a = 0; bus0.dir_b = 0;
      bus0.y_in_a = 0; bus0.y_in_b = 0;
      bus1.btn_a = 0; bus1.btn_b = 0; bus1.dir_a = 0; bus1.dir_b = 0;
      bus1.y_in_a = 0; bus1.y_in_b = 0;
      cyc(2);
      chk("rst_st", int'(bus0.state_o), 0);
      chk_xy("rst", 0, 0);
      chk("rst_sa", int'(bus0.score_a), 0);
      chk("rst_sb", int'(bus0.score_b), 0);
      chk("rst_go", int'(bus0.game_over), 0);
      chk("rst_win", int'(bus0.winner), 0);
      rst = 1'b1;
      cyc(1);

      // serve by A, display dwell, flight to B
      bus0.btn_a = 1; cyc(1); bus0.btn_a = 0;
      chk("disp_in", int'(bus0.state_o), 1);
      cyc(2); chk("disp_hold", int'(bus0.state_o), 1);
      cyc(1); chk("hit_a", int'(bus0.state_o), 2);
      bus0.y_in_a = 2; bus0.dir_a = 2'b01; bus0.btn_a = 1;
      cyc(1);
      bus0.btn_a = 0; bus0.dir_a = 0; bus0.y_in_a = 0;
      chk("send_b", int'(bus0.state_o), 5);
      chk_xy("srv", 0, 2);
      cyc(2); chk("no_step", int'(bus0.x_coord), 0);
      cyc(1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cyc(3);
         chk_xy("fly", xt[i], yt[i]);
      end
      chk("resp_b", int'(bus0.state_o), 7);
      cyc(2); chk("win_open", int'(bus0.state_o), 7);
      cyc(1);
      chk("goal_a", int'(bus0.state_o), 8);
      chk("sa1", int'(bus0.score_a), 1);
      cyc(2); chk("goal_hold", int'(bus0.state_o), 8);
      cyc(1); chk("hit_b", int'(bus0.state_o), 3);

      // B serves straight, A returns, B returns with speed-up
      bus0.y_in_b = 2; bus0.btn_b = 1; cyc(1); bus0.btn_b = 0;
      chk("send_a", int'(bus0.state_o), 4);
      chk_xy("srvb", 4, 2);
      wait_st(0, 6, 20, "resp_a");
      chk_xy("at_a", 0, 2);
      bus0.y_in_a = 2; bus0.btn_a = 1; cyc(1); bus0.btn_a = 0;
      chk("ret_a", int'(bus0.state_o), 5);
      chk_xy("ret_a", 1, 2);
      gap(0, 2, "per2");
      wait_st(0, 7, 20, "resp_b2");
      bus0.dir_b = 2'b10; bus0.btn_b = 1; cyc(1);
      bus0.btn_b = 0; bus0.dir_b = 0;
      chk("ret_b", int'(bus0.state_o), 4);
      chk_xy("ret_b", 3, 1);
      gap(0, 1, "per1");
      chk("refl_y0", int'(bus0.y_coord), 0);
      wait_st(0, 6, 20, "resp_a2");
      chk_xy("at_a2", 0, 2);

      // return on the window-expiring tick beats the goal
      cyc(2); chk("late_open", int'(bus0.state_o), 6);
      bus0.btn_a = 1; cyc(1); bus0.btn_a = 0;
      chk("late_ret", int'(bus0.state_o), 5);
      chk("late_sb", int'(bus0.score_b), 0);
      gap(0, 1, "per_floor");
      wait_st(0, 7, 20, "resp_b3");
      cyc(3);
      chk("goal_a2", int'(bus0.state_o), 8);
      chk("sa2", int'(bus0.score_a), 2);
      wait_st(0, 3, 10, "hit_b2");

      // third point for A, game over
      bus0.y_in_b = 0; bus0.btn_b = 1; cyc(1); bus0.btn_b = 0;
      wait_st(0, 6, 20, "resp_a3");
      bus0.y_in_a = 0; bus0.btn_a = 1; cyc(1); bus0.btn_a = 0;
      wait_st(0, 8, 20, "goal_a3");
      chk("sa3", int'(bus0.score_a), 3);
      wait_st(0, 10, 10, "gover");
      chk("go1", int'(bus0.game_over), 1);
      chk("win0", int'(bus0.winner), 0);
      cyc(2); chk("gover_hold", int'(bus0.state_o), 10);
      cyc(1);
      chk("idle_back", int'(bus0.state_o), 0);
      chk("sa_held", int'(bus0.score_a), 3);
      chk("go_held", int'(bus0.game_over), 1);

      // 8x3 arena: row range and reflection
      bus1.btn_a = 1; cyc(1); bus1.btn_a = 0;
      wait_st(1, 2, 10, "u1_hit_a");
      bus1.y_in_a = 2'd3; bus1.btn_a = 1; cyc(1);
      chk("bad_y", int'(bus1.state_o), 2);
      bus1.y_in_a = 0; bus1.dir_a = 2'b10; cyc(1);
      bus1.btn_a = 0; bus1.dir_a = 0;
      chk("u1_send", int'(bus1.state_o), 5);
      chk("u1_y0", int'(bus1.y_coord), 0);
      for (int i = 0; i < 7; i++) begin
         cyc(3);
         chk("u1_x", int'(bus1.x_coord), i + 1);
         chk("u1_y", int'(bus1.y_coord), y8[i]);
      end
      chk("u1_resp_b", int'(bus1.state_o), 7);

      // both buttons in IDLE: A serves, scores clear
      bus0.btn_a = 1; bus0.btn_b = 1; cyc(1);
      bus0.btn_a = 0; bus0.btn_b = 0;
      chk("clr_st", int'(bus0.state_o), 1);
      chk("clr_sa", int'(bus0.score_a), 0);
      chk("clr_go", int'(bus0.game_over), 0);
      cyc(3); chk("prio_a", int'(bus0.state_o), 2);
      bus0.y_in_a = 1; bus0.btn_a = 1; cyc(1); bus0.btn_a = 0;
      cyc(4);
      chk("mid_st", int'(bus0.state_o), 5);
      chk("mid_x", int'(bus0.x_coord), 1);

      // asynchronous reset mid-flight
      #2 rst = 1'b0;
      #1;
      chk("arst_st", int'(bus0.state_o), 0);
      chk_xy("arst", 0, 0);
      chk("arst_sa", int'(bus0.score_a), 0);
      chk("arst_go", int'(bus0.game_over), 0);
      chk("arst_u1", int'(bus1.state_o), 0);
      @(negedge clk);
      rst = 1'b1;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors",
               nchk, nerr);
      $finish;
   end

endmodule
